// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmit serializer with holding storage, 16x baud timing.
//            Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO, otherwise a
//            single holding register is used.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    tdr_data_i,
    input  logic                          tdr_wr_i,
    input  logic [1:0]                    wls_i,
    input  logic                          stb_i,
    input  logic                          pen_i,
    input  logic                          eps_i,
    input  logic                          brk_i,
    input  logic                          fifo_clr_i,
    input  logic                          bclk_tick_i,
    output logic                          tx_o,
    output logic                          thr_empty_o,
    output logic                          tsr_empty_o,
    output logic                          tx_overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [3:0]    r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [1:0]    r_wls;
    logic          r_stb;
    logic          r_pen;
    logic          r_par;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          r_thr_empty;
    logic          r_tsr_empty;
    logic          r_overflow;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_overflow;
    logic [7:0]    w_head;
    logic          w_bit_done;
    logic          w_frame_end;
    logic          w_pop;
    logic [7:0]    w_par_mask;
    logic          w_par_load;

    assign w_bit_done  = bclk_tick_i && (r_tick_cnt == 4'hF) && (r_state != S_IDLE);
    assign w_frame_end = w_bit_done &&
                         (((r_state == S_STOP1) && !r_stb) || (r_state == S_STOP2));
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);

    // Clear takes priority over a write; a write into full storage survives only with a pop
    assign w_push      = tdr_wr_i && !fifo_clr_i && (!w_full || w_pop);
    assign w_overflow  = tdr_wr_i && !fifo_clr_i && w_full && !w_pop;

    assign w_par_mask  = 8'hFF >> (2'd3 - wls_i);
    assign w_par_load  = eps_i ? (^(w_head & w_par_mask)) : ~(^(w_head & w_par_mask));

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (fifo_clr_i) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (fifo_clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tdr_data_i;
    end
`else
    logic [7:0] r_hold;

    assign w_empty = (r_count == '0);
    assign w_full  = !w_empty;
    assign w_head  = r_hold;

    always_comb begin
        w_count_nxt = r_count;
        if (fifo_clr_i) begin
            w_count_nxt = '0;
        end else if (w_push) begin
            w_count_nxt = CW'(1);
        end else if (w_pop) begin
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= '0;
        end else if (w_push) begin
            r_hold <= tdr_data_i;
        end
    end
`endif

    // State register plus frame datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_wls       <= '0;
            r_stb       <= 1'b0;
            r_pen       <= 1'b0;
            r_par       <= 1'b0;
            r_tx        <= 1'b1;
            r_thr_empty <= 1'b1;
            r_tsr_empty <= 1'b1;
            r_overflow  <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx        <= w_tx_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow;
            r_thr_empty <= (w_count_nxt == '0);
            r_tsr_empty <= (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
            if (w_pop) begin
                r_shift    <= w_head;
                r_wls      <= wls_i;
                r_stb      <= stb_i;
                r_pen      <= pen_i;
                r_par      <= w_par_load;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if ((r_state != S_IDLE) && bclk_tick_i) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
                if (w_bit_done && (r_state == S_DATA)) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_state_nxt = S_START;
            S_START:  if (w_bit_done) w_state_nxt = S_DATA;
            S_DATA:   if (w_bit_done && (r_bit_cnt == ({1'b0, r_wls} + 3'd4)))
                          w_state_nxt = r_pen ? S_PARITY : S_STOP1;
            S_PARITY: if (w_bit_done) w_state_nxt = S_STOP1;
            S_STOP1:  if (w_bit_done)
                          w_state_nxt = r_stb ? S_STOP2 : (w_empty ? S_IDLE : S_START);
            S_STOP2:  if (w_bit_done) w_state_nxt = w_empty ? S_IDLE : S_START;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Line level for the upcoming cycle, registered into r_tx
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = ((r_state == S_DATA) && w_bit_done) ? r_shift[1] : r_shift[0];
            S_PARITY: w_tx_nxt = r_par;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx_o          = brk_i ? 1'b0 : r_tx;
    assign thr_empty_o   = r_thr_empty;
    assign tsr_empty_o   = r_tsr_empty;
    assign tx_overflow_o = r_overflow;
    assign fifo_count_o  = r_count;

endmodule

`default_nettype wire
